// File: rtl/csr_file.sv
// Machine-mode CSR file for the single-cycle RV32I core: combinational read port,
// edge-committed writes, 64-bit cycle/instret counters, trap and mret capture.
module csr_file #(
    parameter logic [31:0] HART_ID  = 32'd0,
    parameter logic [31:0] MISA_VAL = 32'h4000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        csr,
    input  logic [11:0] csr_rd_addr,
    input  logic [31:0] csr_wr_data,
    output logic [31:0] csr_rd_data,
    output logic        csr_illegal,
    input  logic        instr_retire,
    input  logic        trap_valid,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_val,
    input  logic        mret,
    output logic [31:0] mtvec,
    output logic [31:0] mepc,
    output logic [31:0] mstatus
);
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    logic        mie_bit_reg;
    logic        mpie_bit_reg;
    logic [31:0] mie_reg;
    logic [31:0] mtvec_reg;
    logic [31:0] mscratch_reg;
    logic [31:0] mepc_reg;
    logic [31:0] mcause_reg;
    logic [31:0] mtval_reg;
    logic [63:0] count_val [2];

    logic [31:0] rd_data_next;
    logic        implemented;

    logic wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause, wr_mtval;

    assign wr_mstatus  = csr && (csr_rd_addr == 12'h300);
    assign wr_mie      = csr && (csr_rd_addr == 12'h304);
    assign wr_mtvec    = csr && (csr_rd_addr == 12'h305);
    assign wr_mscratch = csr && (csr_rd_addr == 12'h340);
    assign wr_mepc     = csr && (csr_rd_addr == 12'h341);
    assign wr_mcause   = csr && (csr_rd_addr == 12'h342);
    assign wr_mtval    = csr && (csr_rd_addr == 12'h343);

    // MPP is hardwired to machine mode; only MIE and MPIE hold state.
    assign mstatus = {19'd0, 2'b11, 3'd0, mpie_bit_reg, 3'd0, mie_bit_reg, 3'd0};
    assign mtvec   = mtvec_reg;
    assign mepc    = mepc_reg;

    always_comb begin
        rd_data_next = '0;
        implemented  = 1'b1;
        case (csr_rd_addr)
            12'h300:          rd_data_next = mstatus;
            12'h301:          rd_data_next = MISA_VAL;
            12'h304:          rd_data_next = mie_reg;
            12'h305:          rd_data_next = mtvec_reg;
            12'h340:          rd_data_next = mscratch_reg;
            12'h341:          rd_data_next = mepc_reg;
            12'h342:          rd_data_next = mcause_reg;
            12'h343:          rd_data_next = mtval_reg;
            12'h344:          rd_data_next = '0;
            12'hB00, 12'hC00: rd_data_next = count_val[0][31:0];
            12'hB80, 12'hC80: rd_data_next = count_val[0][63:32];
            12'hB02, 12'hC02: rd_data_next = count_val[1][31:0];
            12'hB82, 12'hC82: rd_data_next = count_val[1][63:32];
            12'hF14:          rd_data_next = HART_ID;
            default:          implemented  = 1'b0;
        endcase
    end

    assign csr_rd_data = rd_data_next;
    assign csr_illegal = csr && !implemented;

    always_ff @(posedge clk) begin
        if (reset) begin
            mie_bit_reg  <= 1'b0;
            mpie_bit_reg <= 1'b0;
            mie_reg      <= '0;
            mtvec_reg    <= '0;
            mscratch_reg <= '0;
            mepc_reg     <= '0;
            mcause_reg   <= '0;
            mtval_reg    <= '0;
        end else begin
            // Trap state owns mstatus/mepc/mcause/mtval; other CSR writes still land.
            if (trap_valid) begin
                mpie_bit_reg <= mie_bit_reg;
                mie_bit_reg  <= 1'b0;
                mepc_reg     <= trap_pc & WORD_MASK;
                mcause_reg   <= trap_cause;
                mtval_reg    <= trap_val;
            end else begin
                if (mret) begin
                    mie_bit_reg  <= mpie_bit_reg;
                    mpie_bit_reg <= 1'b1;
                end else if (wr_mstatus) begin
                    mie_bit_reg  <= csr_wr_data[3];
                    mpie_bit_reg <= csr_wr_data[7];
                end
                if (wr_mepc)   mepc_reg   <= csr_wr_data & WORD_MASK;
                if (wr_mcause) mcause_reg <= csr_wr_data;
                if (wr_mtval)  mtval_reg  <= csr_wr_data;
            end
            if (wr_mie)      mie_reg      <= csr_wr_data;
            if (wr_mtvec)    mtvec_reg    <= csr_wr_data & WORD_MASK;
            if (wr_mscratch) mscratch_reg <= csr_wr_data;
        end
    end

    // Counter 0 is mcycle (always counts), counter 1 is minstret (counts retirements).
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_counter
            localparam logic [11:0] LO_ADDR = 12'hB00 + 12'(2 * gi);
            localparam logic [11:0] HI_ADDR = 12'hB80 + 12'(2 * gi);

            logic [63:0] count_reg;
            logic        inc;
            logic        wr_lo;
            logic        wr_hi;

            assign inc   = (gi == 0) ? 1'b1 : instr_retire;
            assign wr_lo = csr && (csr_rd_addr == LO_ADDR);
            assign wr_hi = csr && (csr_rd_addr == HI_ADDR);

            always_ff @(posedge clk) begin
                if (reset) begin
                    count_reg <= '0;
                end else if (wr_lo) begin
                    count_reg[31:0] <= csr_wr_data;
                end else if (wr_hi) begin
                    count_reg[63:32] <= csr_wr_data;
                end else if (inc) begin
                    count_reg <= count_reg + 64'd1;
                end
            end

            assign count_val[gi] = count_reg;
        end
    endgenerate

endmodule
